// File: rtl/out_tx_pkg.sv
// Shared constants, formatter state encoding and decimal digit split for the
// out_decimal_tx console sink.
package out_tx_pkg;

   localparam logic [7:0] ASCII_ZERO = 8'h30;
   localparam logic [7:0] ASCII_NL   = 8'h0A;
   localparam int         FRAME_BITS = 10;

   typedef enum logic [2:0] {
      IDLE,
      D2,
      D1,
      D0,
      NL
   } fmt_state_t;

   typedef struct packed {
      logic [7:0] h;
      logic [7:0] t;
      logic [7:0] o;
   } digits_t;

   function automatic digits_t split_digits(input logic [7:0] v);
      digits_t d;
      d.h = v / 8'd100;
      d.t = (v / 8'd10) % 8'd10;
      d.o = v % 8'd10;
      return d;
   endfunction

endpackage

// File: rtl/uart_tx_bit.sv
// 8N1 UART serializer: start bit, eight data bits LSB first, stop bit, each
// held CLKS_PER_BIT cycles. Ready during the last stop cycle so frames abut.
module uart_tx_bit
   import out_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] data,
   output logic       ready,
   output logic       active,
   output logic       tx
);

   localparam int               CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [3:0]       IDX_LAST  = 4'(FRAME_BITS - 1);
   localparam logic [3:0]       IDX_LAST_DATA = 4'(FRAME_BITS - 2);

   logic [CNT_W-1:0] cnt_q;
   logic [3:0]       idx_q;
   logic [7:0]       data_q;
   logic             active_q;
   logic             tx_q;
   logic             bit_end;
   logic             frame_end;

   assign bit_end   = (cnt_q == CNT_LAST);
   assign frame_end = active_q && bit_end && (idx_q == IDX_LAST);
   assign ready     = !active_q || frame_end;
   assign active    = active_q;
   assign tx        = tx_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q    <= '0;
         idx_q    <= '0;
         data_q   <= '0;
         active_q <= 1'b0;
         tx_q     <= 1'b1;
      end else if (load && ready) begin
         cnt_q    <= '0;
         idx_q    <= '0;
         data_q   <= data;
         active_q <= 1'b1;
         tx_q     <= 1'b0;
      end else if (active_q) begin
         if (bit_end) begin
            cnt_q <= '0;
            if (idx_q == IDX_LAST) begin
               active_q <= 1'b0;
               tx_q     <= 1'b1;
            end else begin
               idx_q <= idx_q + 4'd1;
               // Line value for bit idx_q+1: data bit idx_q, or the stop bit after bit 7.
               tx_q  <= (idx_q == IDX_LAST_DATA) ? 1'b1 : data_q[idx_q[2:0]];
            end
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/out_decimal_tx.sv
// nic8 OUT-port sink: buffers dbus on doOut and transmits each byte as
// three zero-padded decimal digits plus newline over UART 8N1.
//
// state | meaning
// IDLE  | waiting for a buffered byte; pops and splits it into digits
// D2    | hundreds digit offered to the serializer
// D1    | tens digit offered to the serializer
// D0    | ones digit offered to the serializer
// NL    | newline offered to the serializer
module out_decimal_tx
   import out_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       doOut,
   input  logic [7:0] dbus,
   output logic       tx,
   output logic       busy,
   output logic       overflow
);

   localparam int             PTR_W   = $clog2(FIFO_DEPTH);
   localparam int             CNT_W   = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             overflow_q;

   fmt_state_t       state_q;
   logic [7:0]       char_q;
   logic [7:0]       tens_q;
   logic [7:0]       ones_q;

   logic             fifo_empty;
   logic             fifo_full;
   logic             pop;
   logic             push;
   logic             ser_ready;
   logic             ser_active;
   logic             ser_load;
   digits_t          head_digits;

   assign fifo_empty  = (count_q == '0);
   assign fifo_full   = (count_q == DEPTH_C);
   assign pop         = (state_q == IDLE) && !fifo_empty;
   // A pop on the same edge frees the slot, so a full FIFO still accepts.
   assign push        = doOut && (!fifo_full || pop);
   assign head_digits = split_digits(mem_q[rd_ptr_q]);
   assign ser_load    = (state_q != IDLE) && ser_ready;

   assign busy     = !fifo_empty || (state_q != IDLE) || ser_active;
   assign overflow = overflow_q;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= dbus;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
         if (doOut && fifo_full && !pop) begin
            overflow_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         char_q  <= '0;
         tens_q  <= '0;
         ones_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pop) begin
                  char_q  <= ASCII_ZERO + head_digits.h;
                  tens_q  <= head_digits.t;
                  ones_q  <= head_digits.o;
                  state_q <= D2;
               end
            end
            D2: begin
               if (ser_ready) begin
                  char_q  <= ASCII_ZERO + tens_q;
                  state_q <= D1;
               end
            end
            D1: begin
               if (ser_ready) begin
                  char_q  <= ASCII_ZERO + ones_q;
                  state_q <= D0;
               end
            end
            D0: begin
               if (ser_ready) begin
                  char_q  <= ASCII_NL;
                  state_q <= NL;
               end
            end
            NL: begin
               if (ser_ready) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   uart_tx_bit #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_uart (
      .clk   (clk),
      .reset (reset),
      .load  (ser_load),
      .data  (char_q),
      .ready (ser_ready),
      .active(ser_active),
      .tx    (tx)
   );

endmodule

// File: tb/tb_out_decimal_tx.sv
// Directed bench for out_decimal_tx: two instances (4 and 1 clocks per bit)
// with a line decoder that checks bit timing and collects received characters.
module tb_out_decimal_tx;

   logic       clk = 1'b0;
   logic       reset;
   logic       do4, do1;
   logic [7:0] db4, db1;
   logic       tx4, busy4, ovf4;
   logic       tx1, busy1, ovf1;

   int checks    = 0;
   int failures  = 0;
   int frame_err = 0;

   logic [7:0] q0[$];
   logic [7:0] q1[$];
   int         g0[$];
   int         g1[$];
   int         rx_pos  [2];
   int         rx_gap  [2];
   logic [9:0] rx_bits [2];

   always #5 clk = ~clk;

   out_decimal_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut4 (
      .clk(clk), .reset(reset), .doOut(do4), .dbus(db4),
      .tx(tx4), .busy(busy4), .overflow(ovf4)
   );

   out_decimal_tx #(.CLKS_PER_BIT(1), .FIFO_DEPTH(4)) dut1 (
      .clk(clk), .reset(reset), .doOut(do1), .dbus(db1),
      .tx(tx1), .busy(busy1), .overflow(ovf1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Line decoder: sample every falling edge, every sample within a bit must agree.
   initial begin : rx_mon
      for (int l = 0; l < 2; l++) begin
         rx_pos[l]  = -1;
         rx_gap[l]  = 0;
         rx_bits[l] = '0;
      end
      forever begin
         @(negedge clk);
         for (int l = 0; l < 2; l++) begin : per_line
            int   cpb;
            int   n;
            logic v;
            cpb = (l == 0) ? 4 : 1;
            v   = (l == 0) ? tx4 : tx1;
            if (reset !== 1'b0) begin
               rx_pos[l] = -1;
               rx_gap[l] = 0;
            end else if (rx_pos[l] < 0) begin
               if (v === 1'b0) begin
                  rx_bits[l][0] = 1'b0;
                  rx_pos[l]     = 1;
               end else begin
                  rx_gap[l]++;
               end
            end else begin
               n = rx_pos[l];
               if (n % cpb == 0) rx_bits[l][n / cpb] = v;
               else if (v !== rx_bits[l][n / cpb]) frame_err++;
               if (n == 10 * cpb - 1) begin
                  if (rx_bits[l][9] !== 1'b1) frame_err++;
                  if (l == 0) begin
                     q0.push_back(rx_bits[l][8:1]);
                     g0.push_back(rx_gap[l]);
                  end else begin
                     q1.push_back(rx_bits[l][8:1]);
                     g1.push_back(rx_gap[l]);
                  end
                  rx_pos[l] = -1;
                  rx_gap[l] = 0;
               end else begin
                  rx_pos[l] = n + 1;
               end
            end
         end
      end
   end

   task automatic strobe4(input logic [7:0] v);
      @(negedge clk);
      do4 = 1'b1;
      db4 = v;
      @(posedge clk);
   endtask

   task automatic wait_rx(input int line, input int n, input int budget, input string tag);
      int k = 0;
      while (((line == 0) ? q0.size() : q1.size()) < n && k < budget) begin
         @(posedge clk);
         k++;
      end
      chk(tag, (line == 0) ? q0.size() : q1.size(), n);
   endtask

   task automatic wait_idle(input int line, input int budget, input string tag);
      int k = 0;
      while (((line == 0) ? busy4 : busy1) !== 1'b0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk(tag, (line == 0) ? busy4 : busy1, 1'b0);
   endtask

   task automatic check_str(input int line, input string exp, input string tag);
      for (int i = 0; i < exp.len(); i++) begin
         logic [31:0] got;
         if (line == 0) got = (i < q0.size()) ? 32'(q0[i]) : 32'hFFFF_FFFF;
         else           got = (i < q1.size()) ? 32'(q1[i]) : 32'hFFFF_FFFF;
         chk($sformatf("%s[%0d]", tag, i), got, 32'(exp[i]));
      end
   endtask

   task automatic check_gaps(input int line, input string tag);
      int nz = 0;
      if (line == 0) begin
         for (int i = 1; i < g0.size(); i++) if (g0[i] != 0) nz++;
      end else begin
         for (int i = 1; i < g1.size(); i++) if (g1[i] != 0) nz++;
      end
      chk(tag, nz, 0);
   endtask

   initial begin
      reset = 1'b1;
      do4 = 1'b0; db4 = '0;
      do1 = 1'b0; db1 = '0;
      #1;
      chk("rst_tx4", tx4, 1'b1);
      chk("rst_busy4", busy4, 1'b0);
      chk("rst_ovf4", ovf4, 1'b0);
      chk("rst_tx1", tx1, 1'b1);
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // single value 7: latency, 160-cycle duration, busy release
      strobe4(8'd7);
      #1 chk("t1_busy_after_push", busy4, 1'b1);
      @(negedge clk); do4 = 1'b0;
      chk("t1_tx_after_capture", tx4, 1'b1);
      @(negedge clk); chk("t1_tx_after_pop", tx4, 1'b1);
      @(negedge clk); chk("t1_start_after_load", tx4, 1'b0);
      repeat (159) @(negedge clk);
      chk("t1_busy_last_stop", busy4, 1'b1);
      chk("t1_tx_last_stop", tx4, 1'b1);
      @(negedge clk);
      chk("t1_busy_done", busy4, 1'b0);
      wait_rx(0, 4, 50, "t1_count");
      check_str(0, "007\n", "t1_char");
      check_gaps(0, "t1_gaps");

      // back-to-back 255, 0, 100
      q0.delete(); g0.delete();
      strobe4(8'd255);
      strobe4(8'd0);
      strobe4(8'd100);
      @(negedge clk); do4 = 1'b0;
      wait_rx(0, 12, 600, "t2_count");
      check_str(0, "255\n000\n100\n", "t2_char");
      check_gaps(0, "t2_gaps");
      chk("t2_ovf", ovf4, 1'b0);
      wait_idle(0, 200, "t2_idle");

      // six strobes into a depth-4 FIFO: value 6 is dropped
      q0.delete(); g0.delete();
      for (int v = 1; v <= 6; v++) begin
         strobe4(8'(v));
         #1;
         if (v == 5) chk("t3_ovf_at_full", ovf4, 1'b0);
      end
      chk("t3_ovf_set", ovf4, 1'b1);
      @(negedge clk); do4 = 1'b0;
      wait_rx(0, 20, 1000, "t3_count");
      check_str(0, "001\n002\n003\n004\n005\n", "t3_char");
      wait_idle(0, 300, "t3_idle");
      repeat (50) @(negedge clk);
      chk("t3_no_sixth", q0.size(), 20);
      chk("t3_ovf_sticky", ovf4, 1'b1);

      // async reset in data bit 1 of the second character of 42, two bytes queued
      q0.delete(); g0.delete();
      strobe4(8'd42);
      strobe4(8'd9);
      strobe4(8'd13);
      @(negedge clk); do4 = 1'b0;
      repeat (50) @(posedge clk);
      #1;
      chk("t4_tx_low_before_rst", tx4, 1'b0);
      chk("t4_busy_before_rst", busy4, 1'b1);
      #1 reset = 1'b1;
      #1;
      chk("t4_tx_on_rst", tx4, 1'b1);
      chk("t4_busy_on_rst", busy4, 1'b0);
      chk("t4_ovf_on_rst", ovf4, 1'b0);
      @(negedge clk); do4 = 1'b1; db4 = 8'd77;
      @(negedge clk); do4 = 1'b0;
      @(negedge clk); reset = 1'b0;
      repeat (200) @(negedge clk);
      chk("t4_chars_after_rst", q0.size(), 1);
      chk("t4_first_char", (q0.size() > 0) ? 32'(q0[0]) : 32'hFFFF_FFFF, 8'h30);
      chk("t4_tx_idle", tx4, 1'b1);
      chk("t4_busy_idle", busy4, 1'b0);

      // push while full on the exact edge the formatter pops
      q0.delete(); g0.delete();
      strobe4(8'd11);
      strobe4(8'd22);
      strobe4(8'd33);
      strobe4(8'd44);
      strobe4(8'd55);
      @(negedge clk); do4 = 1'b0;
      repeat (118) @(negedge clk);
      do4 = 1'b1; db4 = 8'd66;
      @(posedge clk);
      #1 chk("t5_ovf_clear", ovf4, 1'b0);
      @(negedge clk); do4 = 1'b0;
      wait_rx(0, 24, 1200, "t5_count");
      check_str(0, "011\n022\n033\n044\n055\n066\n", "t5_char");
      wait_idle(0, 200, "t5_idle");
      chk("t5_ovf_end", ovf4, 1'b0);

      // one clock per bit
      q1.delete(); g1.delete();
      @(negedge clk); do1 = 1'b1; db1 = 8'd128;
      @(posedge clk);
      @(negedge clk); do1 = 1'b0;
      wait_rx(1, 4, 100, "t6_count");
      check_str(1, "128\n", "t6_char");
      check_gaps(1, "t6_gaps");
      wait_idle(1, 50, "t6_idle");
      chk("t6_ovf", ovf1, 1'b0);

      chk("frame_errors", frame_err, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
